// File: rtl/reaction_round_ctrl_if.sv
// rtl/reaction_round_ctrl_if.sv - button/counter handshake bundle for the reaction round controller
interface reaction_round_ctrl_if;

    // Timebase and button conditioning inputs
    logic tick;
    logic start_btn;
    logic stop_btn;

    // Status returned by the delay counter
    logic error_long_delay;
    logic record_wait_done;

    // Counter controls
    logic time_clr;
    logic record_wait;
    logic stop;

    // Indicators
    logic led_go;
    logic disp_en;
    logic err_early;
    logic err_long;
    logic busy;

    // Controller side
    modport master (
        input  tick,
        input  start_btn,
        input  stop_btn,
        input  error_long_delay,
        input  record_wait_done,
        output time_clr,
        output record_wait,
        output stop,
        output led_go,
        output disp_en,
        output err_early,
        output err_long,
        output busy
    );

    // Environment side (buttons, counter, display)
    modport slave (
        output tick,
        output start_btn,
        output stop_btn,
        output error_long_delay,
        output record_wait_done,
        input  time_clr,
        input  record_wait,
        input  stop,
        input  led_go,
        input  disp_en,
        input  err_early,
        input  err_long,
        input  busy
    );

endinterface

// File: rtl/reaction_round_ctrl.sv
// rtl/reaction_round_ctrl.sv - reaction timer round sequencer with random pre-delay
module reaction_round_ctrl #(
    parameter int WAIT_MIN        = 1000,
    parameter int WAIT_RANGE_BITS = 10,
    parameter int CNT_W           = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    reaction_round_ctrl_if.master  bus
);

    localparam logic [15:0]      LFSR_SEED  = 16'hACE1;
    localparam logic [CNT_W-1:0] WAIT_MIN_C = CNT_W'(WAIT_MIN);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // One-hot so that a corrupted state register is detectable and recovers to IDLE
    typedef enum logic [7:0] {
        IDLE      = 8'b0000_0001,
        CLEAR     = 8'b0000_0010,
        RAND_WAIT = 8'b0000_0100,
        TIMING    = 8'b0000_1000,
        STOPPING  = 8'b0001_0000,
        DONE      = 8'b0010_0000,
        ERR_EARLY = 8'b0100_0000,
        ERR_LONG  = 8'b1000_0000
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic               start_q;
    logic               stop_q;
    logic               start_rise;
    logic               stop_rise;

    logic [15:0]        lfsr;
    logic [CNT_W-1:0]   wait_cnt;
    logic [CNT_W-1:0]   wait_load;

    logic               time_clr_r;
    logic               record_wait_r;
    logic               stop_r;
    logic               led_go_r;
    logic               disp_en_r;
    logic               err_early_r;
    logic               err_long_r;
    logic               busy_r;

    // Random pre-delay: fixed minimum plus the low LFSR bits
    assign wait_load = WAIT_MIN_C + CNT_W'(lfsr[WAIT_RANGE_BITS-1:0]);

    // Button edge detectors; history resets to 1 so a button held through reset gives no edge
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q    <= 1'b1;
            stop_q     <= 1'b1;
            start_rise <= 1'b0;
            stop_rise  <= 1'b0;
        end else begin
            start_q    <= bus.start_btn;
            stop_q     <= bus.stop_btn;
            start_rise <= bus.start_btn & ~start_q;
            stop_rise  <= bus.stop_btn & ~stop_q;
        end
    end

    // Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), right-shifting form
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
    end

    // Next-state selection; priorities: early stop over expiry, overflow over stop
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_rise) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                state_nxt = RAND_WAIT;
            end
            RAND_WAIT: begin
                if (stop_rise) begin
                    state_nxt = ERR_EARLY;
                end else if (bus.tick && (wait_cnt == CNT_ONE)) begin
                    state_nxt = TIMING;
                end
            end
            TIMING: begin
                if (bus.error_long_delay) begin
                    state_nxt = ERR_LONG;
                end else if (stop_rise) begin
                    state_nxt = STOPPING;
                end
            end
            STOPPING: begin
                if (bus.record_wait_done) begin
                    state_nxt = DONE;
                end
            end
            DONE, ERR_EARLY, ERR_LONG: begin
                if (start_rise) begin
                    state_nxt = CLEAR;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, pre-delay counter and outputs registered together; outputs decode the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            time_clr_r    <= 1'b0;
            record_wait_r <= 1'b0;
            stop_r        <= 1'b0;
            led_go_r      <= 1'b0;
            disp_en_r     <= 1'b0;
            err_early_r   <= 1'b0;
            err_long_r    <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state == CLEAR) begin
                wait_cnt <= wait_load;
            end else if ((state == RAND_WAIT) && bus.tick && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - CNT_ONE;
            end

            time_clr_r    <= (state_nxt == CLEAR);
            record_wait_r <= (state_nxt == TIMING);
            led_go_r      <= (state_nxt == TIMING);
            stop_r        <= (state_nxt == STOPPING) || (state_nxt == DONE) ||
                             (state_nxt == ERR_EARLY) || (state_nxt == ERR_LONG);
            disp_en_r     <= (state_nxt == DONE);
            err_early_r   <= (state_nxt == ERR_EARLY);
            err_long_r    <= (state_nxt == ERR_LONG);
            busy_r        <= (state_nxt == CLEAR) || (state_nxt == RAND_WAIT) ||
                             (state_nxt == TIMING) || (state_nxt == STOPPING);
        end
    end

    assign bus.time_clr    = time_clr_r;
    assign bus.record_wait = record_wait_r;
    assign bus.stop        = stop_r;
    assign bus.led_go      = led_go_r;
    assign bus.disp_en     = disp_en_r;
    assign bus.err_early   = err_early_r;
    assign bus.err_long    = err_long_r;
    assign bus.busy        = busy_r;

endmodule
